// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Board geometry constants and cursor FSM state type, shared by the
//            renderer, board_cursor and game_board.
// Revision : 1.0
// ============================================================================
package game_pkg;

    localparam int C_GRID_N    = 10;
    localparam int C_CELL_SIZE = 40;
    localparam int C_BOARD_X0  = 100;
    localparam int C_BOARD_Y0  = 100;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } cursor_state_t;

endpackage : game_pkg
`default_nettype wire

// File: rtl/board_cursor_if.sv
`default_nettype none
// ============================================================================
// Module   : board_cursor_if
// Brief    : Mouse-in / cell-pick-out bundle between the mouse front end,
//            board_cursor and game_board.
// Revision : 1.0
// ============================================================================
interface board_cursor_if;

    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        pick_ship;
    logic [7:0]  mouse_pos;
    logic        busy;
    logic        cell_valid;

    modport master (
        output xpos, ypos, left,
        input  pick_ship, mouse_pos, busy, cell_valid
    );

    modport slave (
        input  xpos, ypos, left,
        output pick_ship, mouse_pos, busy, cell_valid
    );

endinterface : board_cursor_if
`default_nettype wire

// File: rtl/board_cursor_click_edge.sv
`default_nettype none
// ============================================================================
// Module   : click_edge
// Brief    : Registers a button level and flags its rising edge; one press per
//            hold. Reusable for any button.
// Revision : 1.0
// ============================================================================
module click_edge (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic btn,
    output logic      press
);

    logic r_btn_q;

    // Resetting to 1 keeps a button already held at reset release from firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_q <= 1'b1;
        end else begin
            r_btn_q <= btn;
        end
    end

    assign press = btn & ~r_btn_q;

endmodule : click_edge
`default_nettype wire

// File: rtl/board_cursor.sv
`default_nettype none
// ============================================================================
// Module   : board_cursor
// Brief    : Converts a left click inside the grid into a {row,col} cell index
//            using an iterative subtract divider; flags hover-inside-grid.
// Revision : 1.0
// ============================================================================
module board_cursor
    import game_pkg::*;
#(
    parameter int BOARD_X0  = C_BOARD_X0,
    parameter int BOARD_Y0  = C_BOARD_Y0,
    parameter int CELL_SIZE = C_CELL_SIZE,
    parameter int GRID_N    = C_GRID_N
) (
    input  wire logic     clk,
    input  wire logic     rst,
    board_cursor_if.slave bus
);

    // 13-bit bounds so BOARD_x0 + GRID_N*CELL_SIZE cannot wrap.
    localparam logic [12:0] C_X_LO = 13'(BOARD_X0);
    localparam logic [12:0] C_X_HI = 13'(BOARD_X0 + GRID_N * CELL_SIZE);
    localparam logic [12:0] C_Y_LO = 13'(BOARD_Y0);
    localparam logic [12:0] C_Y_HI = 13'(BOARD_Y0 + GRID_N * CELL_SIZE);
    localparam logic [11:0] C_CELL = 12'(CELL_SIZE);
    localparam logic [11:0] C_X0   = 12'(BOARD_X0);
    localparam logic [11:0] C_Y0   = 12'(BOARD_Y0);

    cursor_state_t r_state;
    logic [11:0]   r_dx;
    logic [11:0]   r_dy;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic [7:0]    r_mouse_pos;
    logic          r_pick_ship;
    logic          r_cell_valid;

    logic          w_press;
    logic          w_inside;
    logic          w_dx_ge;
    logic          w_dy_ge;

    click_edge u_click_edge (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.left),
        .press (w_press)
    );

    assign w_inside = ({1'b0, bus.xpos} >= C_X_LO) && ({1'b0, bus.xpos} < C_X_HI) &&
                      ({1'b0, bus.ypos} >= C_Y_LO) && ({1'b0, bus.ypos} < C_Y_HI);

    assign w_dx_ge = (r_dx >= C_CELL);
    assign w_dy_ge = (r_dy >= C_CELL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_dx         <= 12'd0;
            r_dy         <= 12'd0;
            r_row        <= 4'd0;
            r_col        <= 4'd0;
            r_mouse_pos  <= 8'h00;
            r_pick_ship  <= 1'b0;
            r_cell_valid <= 1'b0;
        end else begin
            r_cell_valid <= w_inside;
            r_pick_ship  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_press && w_inside) begin
                        r_dx    <= bus.xpos - C_X0;
                        r_dy    <= bus.ypos - C_Y0;
                        r_row   <= 4'd0;
                        r_col   <= 4'd0;
                        r_state <= DIV;
                    end
                end
                DIV: begin
                    // Both axes divide in parallel; done once both remainders fit in a cell.
                    if (!w_dx_ge && !w_dy_ge) begin
                        r_mouse_pos <= {r_row, r_col};
                        r_pick_ship <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        if (w_dx_ge) begin
                            r_dx  <= r_dx - C_CELL;
                            r_col <= r_col + 4'd1;
                        end
                        if (w_dy_ge) begin
                            r_dy  <= r_dy - C_CELL;
                            r_row <= r_row + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pick_ship  = r_pick_ship;
    assign bus.mouse_pos  = r_mouse_pos;
    assign bus.cell_valid = r_cell_valid;
    assign bus.busy       = (r_state == DIV);

endmodule : board_cursor
`default_nettype wire

// File: doc/board_cursor.md
# board_cursor

Upstream stage of `game_board` that converts a mouse click in pixel space into a board cell index. On each left-button press inside the 10×10 grid, it computes `{row, col}` with an iterative subtract-divider and issues a one-cycle `pick_ship` pulse together with `mouse_pos`. These drive the matching `game_board` inputs directly. It also flags hover-inside-grid for cursor highlighting.

## Interface
Parameters:
- `BOARD_X0`, default 100: pixel x of the grid's left edge.
- `BOARD_Y0`, default 100: pixel y of the grid's top edge.
- `CELL_SIZE`, default 40: cell edge length in pixels (square cells).
- `GRID_N`, default 10: cells per side.

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `xpos`  in  12: mouse pixel x, synchronous to `clk`.
- `ypos`  in  12: mouse pixel y, synchronous to `clk`.
- `left`  in  1: left button level.
- `pick_ship`  out  1: one-cycle pulse; `mouse_pos` is valid while it is high.
- `mouse_pos`  out  8: `[7:4]` row, `[3:0]` col of the last accepted click.
- `busy`  out  1: high while a conversion is in progress.
- `cell_valid`  out  1: registered; high when the current (`xpos`,`ypos`) lies inside the grid.

## Operation
- Grid rectangle:
  - `BOARD_X0 <= x < BOARD_X0+GRID_N*CELL_SIZE`
  - same rule for y with `BOARD_Y0`.
  - Compare in 13 bits so the bound sum cannot overflow.
- Click detection:
  - `left_q` is `left` registered.
  - A press is `left & ~left_q`.
  - Holding the button yields exactly one press.
- FSM states: `IDLE`, `DIV`.
- `IDLE`:
  - Press with pointer inside the grid: load `dx = xpos-BOARD_X0` and `dy = ypos-BOARD_Y0`, clear `row`/`col`, go to `DIV`.
  - Press outside the grid: ignored; stay in `IDLE`.
- `DIV`, each cycle:
  - If `dx >= CELL_SIZE`: `dx -= CELL_SIZE`, `col++`.
  - If `dy >= CELL_SIZE`: `dy -= CELL_SIZE`, `row++`.
  - Both updates happen in the same cycle.
  - When both `dx < CELL_SIZE` and `dy < CELL_SIZE` on a clock edge: `mouse_pos <= {row,col}`, `pick_ship <= 1`, go to `IDLE`.
- Arithmetic widths:
  - `dx`/`dy`: 12 bits, unsigned.
  - `row`/`col`: 4 bits; they never exceed `GRID_N-1` because the input is range-checked.
- `mouse_pos` holds its value between pulses. `pick_ship` is high for exactly one cycle per accepted click.
- Presses that arrive while in `DIV` are ignored; they are not queued.
- `busy = (state == DIV)`, combinational from the state register.
- Movement of `xpos`/`ypos` during `DIV` has no effect, since the operands were captured on entry.

## Timing
- Reset values:
  - `pick_ship` 0, `mouse_pos` 8'h00, `cell_valid` 0, state `IDLE`.
  - `left_q` resets to 1, so a button already held at reset release does not fire.
- Latency, with E = the edge that samples the press:
  - `DIV` is entered at E.
  - `pick_ship` goes high after edge E+m+1, where m = max(row, col).
  - Cell (0,0): pulse after E+1. Cell (9,9): pulse after E+10.
- Throughput: one click per m+2 cycles at most.
- `cell_valid` lags `xpos`/`ypos` by one cycle.
- Reset mid-`DIV`: the conversion aborts, no pulse is issued, and `mouse_pos` returns to 8'h00.

## Structure
- Shared package `game_pkg`:
  - `GRID_N`, `CELL_SIZE`, `BOARD_X0`, `BOARD_Y0` constants, shared with the renderer and `game_board`.
  - `cursor_state_t` enum {`IDLE`, `DIV`}.
- Natural sub-module: `click_edge`, covering the `left` register and rising-edge detection with reset-to-1 behaviour. It is reusable for other buttons.
- The divider stays inline in this block; it is too small to split out.

## Test plan
- Click at (100,100) → `mouse_pos` = 8'h00; `pick_ship` for 1 cycle after E+1.
- Click at (230,145) → `mouse_pos` = 8'h13; pulse after E+4.
- Click at (499,499) → 8'h99 after E+10. Click at (500,250) or (99,300) → no pulse; `cell_valid` 0; `mouse_pos` unchanged.
- Hold `left` for 50 cycles inside the grid → exactly one pulse. Second press 2 cycles after the first, at (499,499) → ignored; only one pulse.
- Assert `rst` at E+3 of a (9,9) conversion → no pulse ever; all outputs at reset values. Button held through reset release → no pulse.
- Sweep all 100 cell centres → `mouse_pos` == {row,col} and latency == max(row,col)+1 for every cell.
